// File: rtl/adder_pipe_param_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding and
// the helper that derives the pipeline depth from WIDTH and CHUNK.
package adder_pipe_param_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned stage_count(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One registered CHUNK-bit ripple slice of the pipelined adder.
// ADDER_PIPE_OVERFLOW_EN adds a registered signed-overflow flag for the slice MSB.
module adder_pipe_stage #(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_o
`ifdef ADDER_PIPE_OVERFLOW_EN
  ,
  output logic             ovf_o
`endif
);

  logic [CHUNK-1:0] sum_d;
  logic             carry_d;
  logic             valid_q;
  logic [CHUNK-1:0] sum_q;
  logic             carry_q;

`ifdef ADDER_PIPE_OVERFLOW_EN
  logic msb_cin_d;
  logic ovf_q;
`endif

  always_comb begin
    sum_d   = '0;
    carry_d = carry_i;
`ifdef ADDER_PIPE_OVERFLOW_EN
    msb_cin_d = carry_i;
`endif
    for (int i = 0; i < int'(CHUNK); i++) begin
`ifdef ADDER_PIPE_OVERFLOW_EN
      if (i == int'(CHUNK) - 1) msb_cin_d = carry_d;
`endif
      sum_d[i] = a_i[i] ^ b_i[i] ^ carry_d;
      carry_d  = (a_i[i] & b_i[i]) | (carry_d & (a_i[i] ^ b_i[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

`ifdef ADDER_PIPE_OVERFLOW_EN
  // Only meaningful in the stage that owns the operand sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en_i) begin
      ovf_q <= msb_cin_d ^ carry_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/adder_pipe_param.sv
// Pipelined add/subtract, one CHUNK resolved per stage, whole-pipe stall on backpressure.
// Optional ADDER_PIPE_OVERFLOW_EN adds the out_ovf signed-overflow port.
module adder_pipe_param
  import adder_pipe_param_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_op,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADDER_PIPE_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned STAGES = stage_count(WIDTH, CHUNK);

  logic             stall;
  logic             en;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Index k = value presented to stage k (operands) or produced by stage k.
  logic [WIDTH-1:0] opa_in  [STAGES];
  logic [WIDTH-1:0] opb_in  [STAGES];
  logic [WIDTH-1:0] done_w  [STAGES];
  logic [CHUNK-1:0] sum_w   [STAGES];
  logic             valid_w [STAGES];
  logic             carry_w [STAGES];
`ifdef ADDER_PIPE_OVERFLOW_EN
  logic             ovf_w   [STAGES];
`endif

  assign stall  = out_val & ~out_rdy;
  assign en     = ~stall;
  assign in_rdy = en;
  assign accept = in_val & in_rdy;

  // Subtract is a + ~b + 1; the caller's carry-in is ignored then.
  assign b_eff = (in_op == OP_SUB) ? ~in1 : in1;
  assign c0    = (in_op == OP_SUB) ? 1'b1 : in_cin;

  assign opa_in[0] = in0;
  assign opb_in[0] = b_eff;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic stage_vin;
    logic stage_cin;

    if (gi == 0) begin : g_head
      assign stage_vin = accept;
      assign stage_cin = c0;
      assign done_w[0] = WIDTH'(sum_w[0]);
    end else begin : g_body
      // Lower chunks already resolved, travelling alongside this stage's slice.
      logic [WIDTH-1:0] lo_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          lo_q <= '0;
        end else if (en) begin
          lo_q <= done_w[gi-1];
        end
      end

      assign stage_vin  = valid_w[gi-1];
      assign stage_cin  = carry_w[gi-1];
      assign done_w[gi] = lo_q | (WIDTH'(sum_w[gi]) << (gi * CHUNK));
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= opa_in[gi];
          b_q <= opb_in[gi];
        end
      end

      assign opa_in[gi+1] = a_q;
      assign opb_in[gi+1] = b_q;
    end

    adder_pipe_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .valid_i(stage_vin),
      .a_i    (opa_in[gi][gi*CHUNK +: CHUNK]),
      .b_i    (opb_in[gi][gi*CHUNK +: CHUNK]),
      .carry_i(stage_cin),
      .valid_o(valid_w[gi]),
      .sum_o  (sum_w[gi]),
      .carry_o(carry_w[gi])
`ifdef ADDER_PIPE_OVERFLOW_EN
      ,
      .ovf_o  (ovf_w[gi])
`endif
    );
  end

  assign out_val  = valid_w[STAGES-1];
  assign out_sum  = done_w[STAGES-1];
  assign out_cout = carry_w[STAGES-1];

`ifdef ADDER_PIPE_OVERFLOW_EN
  assign out_ovf = ovf_w[STAGES-1];
`endif

endmodule

// File: tb/tb_adder_pipe_param.sv
// Directed bench for adder_pipe_param at 32/8, 16/4 and 8/8 geometries.
// Also checks out_ovf when ADDER_PIPE_OVERFLOW_EN is defined.
module tb_adder_pipe_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_val, in_op, in_cin, out_rdy;
  logic [31:0] in0, in1;
  logic [15:0] in0_16, in1_16;
  logic [7:0]  in0_8, in1_8;
  assign in0_16 = in0[15:0];
  assign in1_16 = in1[15:0];
  assign in0_8  = in0[7:0];
  assign in1_8  = in1[7:0];

  logic        in_rdy, out_val, out_cout;
  logic [31:0] out_sum;
  logic        in_rdy_16, out_val_16, out_cout_16;
  logic [15:0] out_sum_16;
  logic        in_rdy_8, out_val_8, out_cout_8;
  logic [7:0]  out_sum_8;
`ifdef ADDER_PIPE_OVERFLOW_EN
  logic        out_ovf, out_ovf_16, out_ovf_8;
`endif

  adder_pipe_param #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_op(in_op),
    .in_cin(in_cin), .in0(in0), .in1(in1), .out_val(out_val), .out_rdy(out_rdy),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADDER_PIPE_OVERFLOW_EN
    , .out_ovf(out_ovf)
`endif
  );

  adder_pipe_param #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_16), .in_op(in_op),
    .in_cin(in_cin), .in0(in0_16), .in1(in1_16), .out_val(out_val_16), .out_rdy(out_rdy),
    .out_sum(out_sum_16), .out_cout(out_cout_16)
`ifdef ADDER_PIPE_OVERFLOW_EN
    , .out_ovf(out_ovf_16)
`endif
  );

  adder_pipe_param #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy_8), .in_op(in_op),
    .in_cin(in_cin), .in0(in0_8), .in1(in1_8), .out_val(out_val_8), .out_rdy(out_rdy),
    .out_sum(out_sum_8), .out_cout(out_cout_8)
`ifdef ADDER_PIPE_OVERFLOW_EN
    , .out_ovf(out_ovf_8)
`endif
  );

  typedef struct {
    logic        op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference for the narrower geometries: plain wide arithmetic, masked to w bits.
  // Result packing: {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(input int w, input logic op, input logic cin,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [32:0] mask, aa, bb, full;
    logic        cc, ovf;
    mask = (33'd1 << w) - 33'd1;
    aa   = {1'b0, a} & mask;
    bb   = (op ? {1'b0, ~b} : {1'b0, b}) & mask;
    cc   = op ? 1'b1 : cin;
    full = aa + bb + {32'd0, cc};
    ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {ovf, full[w], full[31:0] & mask[31:0]};
  endfunction

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [33:0] e16, e8;
    v   = vecs[idx];
    e16 = model(16, v.op, v.cin, v.a, v.b);
    e8  = model(8, v.op, v.cin, v.a, v.b);
    in_val = 1'b1; in_op = v.op; in_cin = v.cin; in0 = v.a; in1 = v.b;
    @(posedge clk); #1;
    in_val = 1'b0; in0 = $urandom; in1 = $urandom; in_cin = 1'($urandom);
    for (int e = 1; e <= 5; e++) begin
      chk($sformatf("vec%0d_val32_e%0d", idx, e), 32'(out_val), 32'(e == 4));
      chk($sformatf("vec%0d_val16_e%0d", idx, e), 32'(out_val_16), 32'(e == 4));
      chk($sformatf("vec%0d_val8_e%0d", idx, e), 32'(out_val_8), 32'(e == 1));
      if (e == 4) begin
        $display("vec %0d: op=%0d cin=%0d a=%h b=%h -> sum=%h cout=%0d",
                 idx, v.op, v.cin, v.a, v.b, out_sum, out_cout);
        chk($sformatf("vec%0d_sum32", idx), out_sum, v.sum);
        chk($sformatf("vec%0d_cout32", idx), 32'(out_cout), 32'(v.cout));
        chk($sformatf("vec%0d_sum16", idx), 32'(out_sum_16), e16[31:0]);
        chk($sformatf("vec%0d_cout16", idx), 32'(out_cout_16), 32'(e16[32]));
`ifdef ADDER_PIPE_OVERFLOW_EN
        chk($sformatf("vec%0d_ovf32", idx), 32'(out_ovf), 32'(v.ovf));
        chk($sformatf("vec%0d_ovf16", idx), 32'(out_ovf_16), 32'(e16[33]));
`endif
      end
      if (e == 1) begin
        chk($sformatf("vec%0d_sum8", idx), 32'(out_sum_8), e8[31:0]);
        chk($sformatf("vec%0d_cout8", idx), 32'(out_cout_8), 32'(e8[32]));
`ifdef ADDER_PIPE_OVERFLOW_EN
        chk($sformatf("vec%0d_ovf8", idx), 32'(out_ovf_8), 32'(e8[33]));
`endif
      end
      if (e < 5) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] q[$];
    logic [32:0] exp_q;
    logic [31:0] prev_sum;
    logic        stalled_prev;
    int          sent, got;

    //                op    cin   a             b             sum           cout  ovf
    vecs[0] = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h1234_5679, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h00FF_FFFF, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1; in_val = 1'b0; in_op = 1'b0; in_cin = 1'b0; out_rdy = 1'b1;
    in0 = '0; in1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_val", 32'(out_val), 32'd0);
    chk("reset_out_sum", out_sum, 32'd0);
    chk("reset_out_cout", 32'(out_cout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_rdy", 32'(in_rdy), 32'd1);
    chk("post_reset_out_val", 32'(out_val), 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Back-to-back stream: transaction c presented in cycle c appears after its 4th edge.
    for (int c = 0; c < 13; c++) begin
      in_val = (c < 8); in_op = 1'b0; in_cin = 1'b0;
      in0 = 32'(c); in1 = 32'(3 * c);
      @(posedge clk); #1;
      chk($sformatf("stream_val_c%0d", c), 32'(out_val), 32'(c >= 3 && c <= 10));
      chk($sformatf("stream_in_rdy_c%0d", c), 32'(in_rdy), 32'd1);
      if (c >= 3 && c <= 10) begin
        $display("stream result %0d: sum=%h", c - 3, out_sum);
        chk($sformatf("stream_sum_%0d", c - 3), out_sum, 32'(4 * (c - 3)));
      end
    end
    in_val = 1'b0;

    // Stream with out_rdy low for three cycles while results are pending.
    sent = 0; got = 0; stalled_prev = 1'b0; prev_sum = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_rdy = !(cyc >= 6 && cyc <= 8);
      in_val  = (sent < 8); in_op = 1'b0; in_cin = 1'b0;
      in0 = 32'hFFFF_FFF0 + 32'(sent); in1 = 32'h0000_0010;
      #1;
      chk($sformatf("stall_in_rdy_c%0d", cyc), 32'(in_rdy), 32'(!(out_val && !out_rdy)));
      if (out_val && !out_rdy && stalled_prev)
        chk($sformatf("stall_hold_c%0d", cyc), out_sum, prev_sum);
      if (out_val && out_rdy) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL stall_extra: got result %h, expected none", out_sum);
        end else begin
          exp_q = q.pop_front();
          $display("stall result %0d: sum=%h cout=%0d", got, out_sum, out_cout);
          chk($sformatf("stall_sum_%0d", got), out_sum, exp_q[31:0]);
          chk($sformatf("stall_cout_%0d", got), 32'(out_cout), 32'(exp_q[32]));
        end
        got++;
      end
      stalled_prev = out_val && !out_rdy;
      prev_sum = out_sum;
      if (in_val && in_rdy) begin
        q.push_back({1'b1, 32'(sent)});
        sent++;
      end
      @(posedge clk); #1;
    end
    in_val = 1'b0; out_rdy = 1'b1;
    chk("stall_delivered", 32'(got), 32'd8);
    chk("stall_leftover", 32'(q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset with three transactions in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1; in_op = 1'b0; in0 = 32'h0101_0101 * 32'(i + 1); in1 = 32'h10;
      @(posedge clk); #1;
    end
    in_val = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_flight_out_val", 32'(out_val), 32'd0);
    chk("rst_flight_out_sum", out_sum, 32'd0);
    chk("rst_flight_out_cout", 32'(out_cout), 32'd0);
    chk("rst_flight_in_rdy", 32'(in_rdy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_no_stale_%0d", i), 32'(out_val), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
